// File: rtl/tff_bank_counter.sv
// WIDTH-bit toggle/count/load register bank with registered terminal-count
// pulse and a registered mask of the bits that changed on the last edge.
module tff_bank_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter longint unsigned  MODULUS     = 64'd1 << WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_t,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic [WIDTH-1:0] o_toggled
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  // Highest in-range count value; anything at or above it wraps in count mode.
  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] r_toggled;

  logic [WIDTH-1:0] w_q_n;
  logic             w_wrap;
  logic             w_at_last;
  mode_e            w_mode;

  assign w_mode    = mode_e'(i_mode);
  assign w_at_last = (r_q >= C_LAST);

  always_comb begin
    w_q_n  = r_q;
    w_wrap = 1'b0;
    if (i_enable) begin
      case (w_mode)
        MODE_TOGGLE: w_q_n = r_q ^ i_t;
        MODE_COUNT: begin
          w_wrap = w_at_last;
          w_q_n  = w_at_last ? '0 : r_q + WIDTH'(1);
        end
        MODE_LOAD:   w_q_n = i_d;
        default:     w_q_n = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q       <= RESET_VALUE;
      r_tc      <= 1'b0;
      r_toggled <= '0;
    end else begin
      r_q       <= w_q_n;
      r_tc      <= w_wrap;
      r_toggled <= r_q ^ w_q_n;
    end
  end

  assign o_q       = r_q;
  assign o_tc      = r_tc;
  assign o_toggled = r_toggled;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Directed bench for tff_bank_counter: a MODULUS=10 instance and a MODULUS=16
// instance (reset value 4'hA) share the same clock, reset and inputs.
module tb_tff_bank_counter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] t;
  logic [3:0] d;

  logic [3:0] q_a, tog_a, q_b, tog_b;
  logic       tc_a, tc_b;

  int checks   = 0;
  int failures = 0;

  tff_bank_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(4'h0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
    .i_t(t), .i_d(d), .o_q(q_a), .o_tc(tc_a), .o_toggled(tog_a)
  );

  tff_bank_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(4'hA)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
    .i_t(t), .i_d(d), .o_q(q_b), .o_tc(tc_b), .o_toggled(tog_b)
  );

  // Clock: rising edges at 5, 15, 25 ns ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic en, input logic [1:0] md,
                      input logic [3:0] tv, input logic [3:0] dv);
    @(negedge clk);
    enable = en;
    mode   = md;
    t      = tv;
    d      = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (q_a !== 4'h0 || tc_a !== 1'b0 || tog_a !== 4'h0) begin
      failures++;
      $display("FAIL reset_async_a: q=%h tc=%b tog=%h, want q=0 tc=0 tog=0", q_a, tc_a, tog_a);
    end
    checks++;
    if (q_b !== 4'hA || tc_b !== 1'b0 || tog_b !== 4'h0) begin
      failures++;
      $display("FAIL reset_async_b: q=%h tc=%b tog=%h, want q=a tc=0 tog=0", q_b, tc_b, tog_b);
    end
    enable = 1'b1;
    mode   = 2'b11;
    d      = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q_a !== 4'h0 || tc_a !== 1'b0 || tog_a !== 4'h0) begin
      failures++;
      $display("FAIL reset_held: q=%h tc=%b tog=%h, want q=0 tc=0 tog=0", q_a, tc_a, tog_a);
    end
    @(negedge clk);
    mode  = 2'b00;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_toggle;
    step(1'b1, 2'b11, 4'h0, 4'b0101);
    checks++;
    if (q_a !== 4'b0101) begin
      failures++;
      $display("FAIL toggle_load: q=%b, want 0101", q_a);
    end
    step(1'b1, 2'b01, 4'b0011, 4'h0);
    checks++;
    if (q_a !== 4'b0110 || tog_a !== 4'b0011 || tc_a !== 1'b0) begin
      failures++;
      $display("FAIL toggle_1: q=%b tog=%b tc=%b, want q=0110 tog=0011 tc=0", q_a, tog_a, tc_a);
    end
    step(1'b1, 2'b01, 4'b0011, 4'h0);
    checks++;
    if (q_a !== 4'b0101 || tog_a !== 4'b0011) begin
      failures++;
      $display("FAIL toggle_2: q=%b tog=%b, want q=0101 tog=0011", q_a, tog_a);
    end
    step(1'b1, 2'b01, 4'b0000, 4'h0);
    checks++;
    if (q_a !== 4'b0101 || tog_a !== 4'b0000) begin
      failures++;
      $display("FAIL toggle_zero: q=%b tog=%b, want q=0101 tog=0000", q_a, tog_a);
    end
    step(1'b1, 2'b01, 4'b1111, 4'h0);
    checks++;
    if (q_a !== 4'b1010 || tog_a !== 4'b1111) begin
      failures++;
      $display("FAIL toggle_all: q=%b tog=%b, want q=1010 tog=1111", q_a, tog_a);
    end
  endtask

  task automatic test_count_wrap;
    logic [3:0] exp_q   [4] = '{4'd8, 4'd9, 4'd0, 4'd1};
    logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_tog [4] = '{4'b1111, 4'b0001, 4'b1001, 4'b0001};
    step(1'b1, 2'b11, 4'h0, 4'd7);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10, 4'h0, 4'h0);
      checks++;
      if (q_a !== exp_q[i] || tc_a !== exp_tc[i] || tog_a !== exp_tog[i]) begin
        failures++;
        $display("FAIL count_wrap_%0d: q=%0d tc=%b tog=%b, want q=%0d tc=%b tog=%b",
                 i, q_a, tc_a, tog_a, exp_q[i], exp_tc[i], exp_tog[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    step(1'b1, 2'b11, 4'h0, 4'hC);
    checks++;
    if (q_a !== 4'hC) begin
      failures++;
      $display("FAIL oor_load: q=%h, want c", q_a);
    end
    step(1'b1, 2'b10, 4'h0, 4'h0);
    checks++;
    if (q_a !== 4'h0 || tc_a !== 1'b1 || tog_a !== 4'hC) begin
      failures++;
      $display("FAIL oor_wrap: q=%h tc=%b tog=%h, want q=0 tc=1 tog=c", q_a, tc_a, tog_a);
    end
    step(1'b1, 2'b11, 4'h0, 4'hF);
    step(1'b1, 2'b10, 4'h0, 4'h0);
    checks++;
    if (q_b !== 4'h0 || tc_b !== 1'b1 || tog_b !== 4'hF) begin
      failures++;
      $display("FAIL mod16_wrap: q=%h tc=%b tog=%h, want q=0 tc=1 tog=f", q_b, tc_b, tog_b);
    end
    step(1'b1, 2'b11, 4'h0, 4'd9);
    step(1'b1, 2'b10, 4'h0, 4'h0);
    checks++;
    if (q_b !== 4'hA || tc_b !== 1'b0) begin
      failures++;
      $display("FAIL mod16_no_wrap_at_9: q=%h tc=%b, want q=a tc=0", q_b, tc_b);
    end
    checks++;
    if (q_a !== 4'h0 || tc_a !== 1'b1) begin
      failures++;
      $display("FAIL mod10_wrap_at_9: q=%h tc=%b, want q=0 tc=1", q_a, tc_a);
    end
  endtask

  task automatic test_enable_hold;
    step(1'b1, 2'b11, 4'h0, 4'd2);
    step(1'b1, 2'b10, 4'h0, 4'h0);
    checks++;
    if (q_a !== 4'd3) begin
      failures++;
      $display("FAIL hold_setup: q=%0d, want 3", q_a);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b10, 4'hF, 4'hF);
      checks++;
      if (q_a !== 4'd3 || tc_a !== 1'b0 || tog_a !== 4'h0) begin
        failures++;
        $display("FAIL hold_disabled_%0d: q=%0d tc=%b tog=%h, want q=3 tc=0 tog=0",
                 i, q_a, tc_a, tog_a);
      end
    end
    step(1'b1, 2'b00, 4'hF, 4'hF);
    checks++;
    if (q_a !== 4'd3 || tog_a !== 4'h0) begin
      failures++;
      $display("FAIL hold_mode00: q=%0d tog=%h, want q=3 tog=0", q_a, tog_a);
    end
    step(1'b1, 2'b10, 4'h0, 4'h0);
    checks++;
    if (q_a !== 4'd4 || tc_a !== 1'b0 || tog_a !== 4'b0111) begin
      failures++;
      $display("FAIL hold_resume: q=%0d tc=%b tog=%b, want q=4 tc=0 tog=0111", q_a, tc_a, tog_a);
    end
  endtask

  task automatic test_reset_mid_count;
    step(1'b1, 2'b11, 4'h0, 4'd5);
    step(1'b1, 2'b10, 4'h0, 4'h0);
    checks++;
    if (q_a !== 4'd6) begin
      failures++;
      $display("FAIL midrst_setup: q=%0d, want 6", q_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q_a !== 4'd0 || tc_a !== 1'b0 || tog_a !== 4'h0 || q_b !== 4'hA) begin
      failures++;
      $display("FAIL midrst_async: q_a=%0d tc=%b tog=%h q_b=%h, want q_a=0 tc=0 tog=0 q_b=a",
               q_a, tc_a, tog_a, q_b);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q_a !== 4'd1 || tc_a !== 1'b0 || tog_a !== 4'd1) begin
      failures++;
      $display("FAIL midrst_release: q=%0d tc=%b tog=%h, want q=1 tc=0 tog=1", q_a, tc_a, tog_a);
    end
    checks++;
    if (q_b !== 4'hB || tc_b !== 1'b0) begin
      failures++;
      $display("FAIL midrst_release_b: q=%h tc=%b, want q=b tc=0", q_b, tc_b);
    end
  endtask

  task automatic test_back_to_back;
    int tc_count;
    tc_count = 0;
    step(1'b1, 2'b11, 4'h0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'b10, 4'h0, 4'h0);
      if (tc_a === 1'b1) tc_count++;
    end
    checks++;
    if (tc_count != 2 || q_a !== 4'd0) begin
      failures++;
      $display("FAIL b2b_count: tc_pulses=%0d q=%0d, want tc_pulses=2 q=0", tc_count, q_a);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    t      = 4'h0;
    d      = 4'h0;
    test_reset;
    test_toggle;
    test_count_wrap;
    test_out_of_range;
    test_enable_hold;
    test_reset_mid_count;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
